// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Register scoreboard and issue controller for the decode stage. Each of
//   x1..x31 has a 3-bit countdown to its register-file write. The decoded
//   instruction is held (stall) while any source it reads is not yet
//   readable (RAW), or while its destination still has an older write in
//   flight (WAW).
//
// Parameters
//   ALU_LAT    issue-to-writeback latency of normal ops (1..7)
//   LONG_LAT   issue-to-writeback latency when i_long_op=1 (1..7)
//   WB_BYPASS  1: the register file writes through, so a source is ready at cnt<=1
//              0: a source is ready only at cnt==0
//   CNT_W      width of the saturating stall counter
//
// Ports
//   i_clk, i_rst       rising-edge clock, asynchronous active-high reset
//   i_issue_valid      decode holds a valid instruction
//   i_reg_num_1/2      rs1/rs2 indices; i_use_rs_1/2 qualify them
//   i_rd_num, i_rd_we  destination index and write enable
//   i_long_op          selects LONG_LAT instead of ALU_LAT
//   stall              combinational: hold decode/fetch and inject a bubble
//   issue              combinational: i_issue_valid & ~stall
//   busy_mask          registered: bit r = (cnt[r] != 0); bit 0 is always 0
//   stall_cnt          registered: saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int ALU_LAT   = 3,
    parameter int LONG_LAT  = 5,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_issue_valid,
    input  logic [4:0]       i_reg_num_1,
    input  logic [4:0]       i_reg_num_2,
    input  logic             i_use_rs_1,
    input  logic             i_use_rs_2,
    input  logic [4:0]       i_rd_num,
    input  logic             i_rd_we,
    input  logic             i_long_op,
    output logic             stall,
    output logic             issue,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] ALU_LAT_C  = 3'(ALU_LAT);
    localparam logic [2:0] LONG_LAT_C = 3'(LONG_LAT);

    // Entry 0 exists only to keep indexing simple; it is held at zero.
    logic [31:0][2:0]  r_cnt;
    logic [31:0]       r_busy;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [31:0][2:0]  w_cnt_nxt;
    logic [31:0]       w_busy_nxt;
    logic [2:0]        w_lat;
    logic              w_raw;
    logic              w_waw;
    logic              w_stall;
    logic              w_issue;

    // A source is readable when it is x0 or its pending write lands in time.
    function automatic logic f_ready(input logic [4:0] r, input logic [2:0] c);
        logic ok;
        if (r == 5'd0) begin
            ok = 1'b1;
        end else if (WB_BYPASS != 0) begin
            ok = (c <= 3'd1);
        end else begin
            ok = (c == 3'd0);
        end
        return ok;
    endfunction

    // Hazard detection against pre-issue counts, and next-state counters.
    always_comb begin
        w_raw      = 1'b0;
        w_waw      = 1'b0;
        w_stall    = 1'b0;
        w_issue    = 1'b0;
        w_lat      = ALU_LAT_C;
        w_cnt_nxt  = '0;
        w_busy_nxt = 32'd0;

        w_raw = (i_use_rs_1 & ~f_ready(i_reg_num_1, r_cnt[i_reg_num_1]))
              | (i_use_rs_2 & ~f_ready(i_reg_num_2, r_cnt[i_reg_num_2]));
        // WAW waits for full retirement, independent of write-through.
        w_waw   = i_rd_we & (i_rd_num != 5'd0) & (r_cnt[i_rd_num] != 3'd0);
        w_stall = i_issue_valid & (w_raw | w_waw);
        w_issue = i_issue_valid & ~w_stall;

        if (i_long_op) begin
            w_lat = LONG_LAT_C;
        end else begin
            w_lat = ALU_LAT_C;
        end

        for (int r = 1; r < 32; r++) begin
            // A new write's load wins over the decrement; WAW ensures old cnt was 0.
            if (w_issue && i_rd_we && (i_rd_num == 5'(r))) begin
                w_cnt_nxt[r] = w_lat;
            end else if (r_cnt[r] != 3'd0) begin
                w_cnt_nxt[r] = r_cnt[r] - 3'd1;
            end else begin
                w_cnt_nxt[r] = 3'd0;
            end
            w_busy_nxt[r] = (w_cnt_nxt[r] != 3'd0);
        end
    end

    // Counter array and the busy mask that mirrors it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_busy <= 32'd0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall     = w_stall;
    assign issue     = w_issue;
    assign busy_mask = r_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        lng;
        logic        e_stall;
        logic        e_issue;
        logic [31:0] e_busy;
        logic [31:0] e_scnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, we, lng;

    logic        st_a, is_a, st_b, is_b, st_c, is_c;
    logic [31:0] bm_a, bm_b, bm_c;
    logic [31:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .i_clk(clk), .i_rst(rst), .i_issue_valid(valid),
        .i_reg_num_1(rs1), .i_reg_num_2(rs2), .i_use_rs_1(u1), .i_use_rs_2(u2),
        .i_rd_num(rd), .i_rd_we(we), .i_long_op(lng),
        .stall(st_a), .issue(is_a), .busy_mask(bm_a), .stall_cnt(sc_a)
    );

    hazard_scoreboard #(.WB_BYPASS(0)) u_nb (
        .i_clk(clk), .i_rst(rst), .i_issue_valid(valid),
        .i_reg_num_1(rs1), .i_reg_num_2(rs2), .i_use_rs_1(u1), .i_use_rs_2(u2),
        .i_rd_num(rd), .i_rd_we(we), .i_long_op(lng),
        .stall(st_b), .issue(is_b), .busy_mask(bm_b), .stall_cnt(sc_b)
    );

    hazard_scoreboard #(.CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_issue_valid(valid),
        .i_reg_num_1(rs1), .i_reg_num_2(rs2), .i_use_rs_1(u1), .i_use_rs_2(u2),
        .i_rd_num(rd), .i_rd_we(we), .i_long_op(lng),
        .stall(st_c), .issue(is_c), .busy_mask(bm_c), .stall_cnt(sc_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic ua, input logic ub, input logic [4:0] d,
                         input logic w, input logic l);
        valid = v; rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; we = w; lng = l;
    endtask

    task automatic addv(input logic v, input logic [4:0] a, input logic [4:0] b,
                        input logic ua, input logic ub, input logic [4:0] d,
                        input logic w, input logic l, input logic es, input logic ei,
                        input logic [31:0] eb, input logic [31:0] esc);
        vec_t t;
        t.valid = v; t.rs1 = a; t.rs2 = b; t.u1 = ua; t.u2 = ub; t.rd = d;
        t.we = w; t.lng = l; t.e_stall = es; t.e_issue = ei; t.e_busy = eb; t.e_scnt = esc;
        vq.push_back(t);
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Scenario 1: RAW behind an ALU write of x5
        addv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'd0);
        addv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'd0);
        addv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'd1);
        addv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'd2);
        // Scenario 2: x0 destination never becomes busy
        addv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'd2);
        addv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'd2);
        // Scenario 3: long op x7; unused rs2 does not stall; valid=0 never stalls
        addv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'd2);
        addv(1'b1, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'd2);
        addv(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'd2);
        for (int i = 0; i < 3; i++)
            addv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'd2);
        addv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'd2);
        for (int i = 0; i < 4; i++)
            addv(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'(2 + i));
        addv(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'd6);
        // Scenario 4: WAW on x3 waits for full retirement, then reloads 3
        addv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'd6);
        for (int i = 0; i < 3; i++)
            addv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'(6 + i));
        addv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'd9);
        for (int i = 0; i < 3; i++)
            addv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'd9);
        addv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd9);
        // rs1 == rd: first issues on pre-issue counts, repeat stalls on RAW then WAW
        addv(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'd9);
        for (int i = 0; i < 3; i++)
            addv(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'(9 + i));
        addv(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'd12);
        addv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd12);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 5'd5, 5'd9, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        #2;
        chk("rst_stall", {31'd0, st_a}, 32'd0);
        chk("rst_busy", bm_a, 32'd0);
        chk("rst_scnt", sc_a, 32'd0);
        chk("rst_scnt_sat", {28'd0, sc_c}, 32'd0);
        do_reset();

        // Table-driven main run on the default instance
        foreach (vq[i]) begin
            drive(vq[i].valid, vq[i].rs1, vq[i].rs2, vq[i].u1, vq[i].u2,
                  vq[i].rd, vq[i].we, vq[i].lng);
            #2;
            chk($sformatf("v%0d_stall", i), {31'd0, st_a}, {31'd0, vq[i].e_stall});
            chk($sformatf("v%0d_issue", i), {31'd0, is_a}, {31'd0, vq[i].e_issue});
            chk($sformatf("v%0d_busy", i), bm_a, vq[i].e_busy);
            chk($sformatf("v%0d_scnt", i), sc_a, vq[i].e_scnt);
            @(negedge clk);
        end

        // WB_BYPASS=0: RAW on x5 stalls 3 cycles
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
            #2;
            chk($sformatf("nb%0d_stall", k), {31'd0, st_b}, (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("nb%0d_issue", k), {31'd0, is_b}, (k == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("nb_scnt", sc_b, 32'd3);

        // Asynchronous reset mid-count discards the pending long op on x9
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("ar_pre_stall", {31'd0, st_a}, 32'd1);
        chk("ar_pre_busy", bm_a, 32'h200);
        #1 rst = 1'b1;
        #1;
        chk("ar_busy", bm_a, 32'd0);
        chk("ar_stall", {31'd0, st_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("ar_issue", {31'd0, is_a}, 32'd1);

        // Saturation: repeated long ops to x8 that also read x8
        do_reset();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        #2;
        chk("sat_scnt4", {28'd0, sc_c}, 32'd15);
        chk("sat_scnt32", sc_a, 32'd25);
        chk("sat_scnt_nb", sc_b, 32'd25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
